// File: rtl/digit_scan_ctrl_pkg.sv
// Shared definitions for the miniRV 7-segment display peripheral:
// register offsets and the active-low hex glyph table.
package digit_scan_ctrl_pkg;

    localparam int REG_DATA  = 'h000;
    localparam int REG_EN    = 'h004;
    localparam int REG_DP    = 'h008;
    localparam int REG_BLINK = 'h00C;

    // Bits 6..0 map to segments a..g, 0 = lit.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h0C, 7'h08, 7'h60,
        7'h72, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low 7-segment glyph {a,b,c,d,e,f,g}.
// Purely combinational; shared by display drivers.
module seg7_hex_decode
    import digit_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/digit_scan_ctrl.sv
// Memory-mapped multiplexed 7-segment driver with per-digit enable,
// decimal point and blink, scanning one digit per SCAN_CYCLES slot.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_CYCLES  = 30000,
    parameter int BLINK_FRAMES = 64,
    parameter int ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wen,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [7:0]        dig_en,
    output logic [7:0]        seg
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_CYCLES);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0]         data_r;
    logic [NUM_DIGITS-1:0] en_r;
    logic [NUM_DIGITS-1:0] dp_r;
    logic [NUM_DIGITS-1:0] blink_r;

    logic [CW-1:0] scan_cnt;
    logic [IW-1:0] idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic          tick;
    logic          frame_end;

    logic          sel_data;
    logic          sel_en;
    logic          sel_dp;
    logic          sel_blink;

    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic          visible;
    logic [7:0]    dig_nx;
    logic [7:0]    seg_nx;

    assign sel_data  = (addr == ADDR_W'(REG_DATA));
    assign sel_en    = (addr == ADDR_W'(REG_EN));
    assign sel_dp    = (addr == ADDR_W'(REG_DP));
    assign sel_blink = (addr == ADDR_W'(REG_BLINK));

    assign tick      = (scan_cnt == CW'(SCAN_CYCLES - 1));
    assign frame_end = tick && (idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= '0;
            en_r    <= '1;
            dp_r    <= '0;
            blink_r <= '0;
        end else if (wen) begin
            unique case (1'b1)
                sel_data:  data_r  <= wdata[DW-1:0];
                sel_en:    en_r    <= wdata[NUM_DIGITS-1:0];
                sel_dp:    dp_r    <= wdata[NUM_DIGITS-1:0];
                sel_blink: blink_r <= wdata[NUM_DIGITS-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt    <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
            if (tick) begin
                idx <= frame_end ? '0 : idx + 1'b1;
            end
            if (frame_end) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    seg7_hex_decode u_dec (
        .nibble (nib),
        .glyph  (glyph)
    );

    // Blanked digits keep their slot; only the drive is suppressed.
    always_comb begin
        nib     = data_r[4*int'(idx) +: 4];
        visible = en_r[idx] & (~blink_r[idx] | blink_phase);
        dig_nx  = 8'hFF;
        seg_nx  = 8'hFF;
        if (visible) begin
            dig_nx = ~(8'd1 << idx);
            seg_nx = {glyph, ~dp_r[idx]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_en <= 8'hFF;
            seg    <= 8'hFF;
        end else begin
            dig_en <= dig_nx;
            seg    <= seg_nx;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_data:  rdata = 32'(data_r);
            sel_en:    rdata = 32'(en_r);
            sel_dp:    rdata = 32'(dp_r);
            sel_blink: rdata = 32'(blink_r);
            default:   rdata = '0;
        endcase
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Memory-mapped, parametrised driver for a multiplexed 7-segment display, attached to the miniRV peripheral bus.
- Holds one hex nibble per digit and scans digits one at a time with active-low digit enables.
- Adds over the current single-register driver: configurable digit count and scan rate, per-digit enable mask, decimal-point mask, per-digit blink, and register readback.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..8.
- SCAN_CYCLES, 30000, clk cycles each digit stays lit; must be ≥2.
- BLINK_FRAMES, 64, full scan frames per blink half-period; must be ≥1.
- ADDR_W, 12, width of bus address.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  ADDR_W  byte address, offset within the peripheral window.
- wen  in  1  write strobe, sampled on the rising clk edge.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr.
- dig_en  out  8  active-low one-hot digit select; bits ≥ NUM_DIGITS are tied 1.
- seg  out  8  active-low segments {a,b,c,d,e,f,g,dp}; dp is bit 0.

Behaviour:
- Register map (word offsets; write when wen=1 and addr matches; any other address ignores the write and reads 0):
  - 0x000 DATA[4*NUM_DIGITS-1:0]: nibble i is shown on digit i; upper bits read 0.
  - 0x004 EN[NUM_DIGITS-1:0]: digit enable mask.
  - 0x008 DP[NUM_DIGITS-1:0]: decimal point on when bit=1.
  - 0x00C BLINK[NUM_DIGITS-1:0]: digit blinks when bit=1.
- Reset values:
  - DATA=0, EN=all ones, DP=0, BLINK=0.
  - dig_en=8'hFF, seg=8'hFF.
  - Scan counter=0, digit index=0, frame counter=0, blink_phase=1 (visible).
- Scan counter:
  - Counts 0..SCAN_CYCLES-1.
  - tick=1 when counter==SCAN_CYCLES-1; the counter wraps to 0 on the same cycle.
- Digit index:
  - Advances by 1 on tick and wraps NUM_DIGITS-1 → 0.
  - A frame ends on a tick with index==NUM_DIGITS-1.
- Blink:
  - Frame counter counts frame ends 0..BLINK_FRAMES-1.
  - On wrap, blink_phase toggles.
  - Blink half-period is SCAN_CYCLES·NUM_DIGITS·BLINK_FRAMES cycles.
- Outputs are registered and update every cycle from the current index i:
  - visible(i) = EN[i] & (~BLINK[i] | blink_phase).
  - dig_en = visible ? ~(1<<i) : 8'hFF.
  - seg[7:1] = active-low hex glyph of DATA nibble i. Glyphs, listed as bits 7..1 (a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, c=1110010, d=1000010, E=0110000, F=0111000.
  - seg[0] = ~DP[i].
  - When not visible, seg=8'hFF.
- Latency:
  - The first output edge after reset release shows digit 0 (dig_en=8'hFE if EN[0]).
  - A register write is reflected on the outputs 2 edges after the write edge (register, then output flop).
- Blanked digits still consume their SCAN_CYCLES slot, so scan timing is independent of the masks.
- A write to EN, BLINK or DATA on the same cycle as a tick is applied normally; there is no interaction with the scan.
- Asserting rst mid-scan returns all state to the reset values immediately.
- rdata = register value zero-extended to 32 bits.

Decomposition:
- Shared package for the peripheral bus: register offsets (DATA/EN/DP/BLINK) and the hex glyph constant table.
- One natural sub-module, seg7_hex_decode: combinational nibble → 7-bit active-low glyph. It is reusable by other display drivers.
- Scan, blink and register logic stay in digit_scan_ctrl.

Test Plan:
- Reset, SCAN_CYCLES=4, NUM_DIGITS=8 → dig_en steps FE,FD,FB,…,7F, each held 4 cycles, then wraps to FE; seg shows glyph "0" (8'h03) on every digit.
- Write DATA=32'h89ABCDEF, DP=8'h01 → digit 0 seg=8'h70 (F, dp lit); digit 7 seg=8'h01 (8, dp off); change visible 2 edges after the write.
- Write EN=8'hF0 → during slots 0..3 dig_en=FF and seg=FF; slots 4..7 are driven normally; slot durations are unchanged.
- BLINK=8'h02, BLINK_FRAMES=2 → digit 1 visible for 2 frames, blank for 2 frames, repeating; the other digits are never blanked.
- NUM_DIGITS=4 → dig_en cycles F E,D,B,7 with bits 7:4 always 1; a write of DATA=32'hFFFF1234 reads back 32'h00001234.
- Reads of 0x010 and writes to 0x010 → rdata=0 and no register changes; rst asserted mid-slot → dig_en=FF and seg=FF asynchronously, and the scan restarts at digit 0.
